// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter: round-robin arbiter/sequencer sharing one multi-precision
// adder between two requesters. One operation is in flight at a time: the
// operands are registered on accept, the adder is started one cycle later, and
// the result is routed back to the port that issued the operation.
module mpadder_arbiter #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,

  output logic             resp0_valid,
  output logic [WIDTH:0]   resp0_result,
  output logic             resp1_valid,
  output logic [WIDTH:0]   resp1_result,

  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done,

  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             sel0;
  logic             sel1;
  logic             accept;

  // Grant selection: only in IDLE, a lone requester wins, a tie goes to prio.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        sel0 = ~prio;
        sel1 = prio;
      end else begin
        sel0 = req0_valid;
        sel1 = req1_valid;
      end
    end
  end

  assign req0_ready = sel0;
  assign req1_ready = sel1;
  assign accept     = sel0 | sel1;

  // Operand capture on accept; held stable for the adder until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
    end else if (accept) begin
      op_a   <= sel1 ? req1_a   : req0_a;
      op_b   <= sel1 ? req1_b   : req0_b;
      op_sub <= sel1 ? req1_sub : req0_sub;
    end
  end

  assign add_in_a     = op_a;
  assign add_in_b     = op_b;
  assign add_subtract = op_sub;

  // Sequencer FSM with registered start/busy/grant and per-port responses.
  // A done level seen in ISSUE may be left over from the previous operation,
  // so only WAIT looks at add_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= 1'b0;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_result <= '0;
    end else begin
      add_start   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id  <= sel1;
            prio      <= ~sel1;
            busy      <= 1'b1;
            add_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (add_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (grant_id) begin
              resp1_result <= add_result;
              resp1_valid  <= 1'b1;
            end else begin
              resp0_result <= add_result;
              resp0_valid  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
